// File: rtl/bm_dag_defs.sv
// Shared definitions for the DAG logic pipeline: op-mode encodings and default sizing.
package bm_dag_defs;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } dag_op_e;

    localparam int DEF_WIDTH = 2;
    localparam int DEF_DEPTH = 3;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/bm_dag_stage.sv
// One registered logic cell of the DAG pipeline; loads only when the upstream stage is valid.
// Optional DAG_PARITY_EN adds a parity register that tracks the loaded x/s pair.
module bm_dag_stage
    import bm_dag_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             v_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             s_i,
    input  logic [1:0]       m_i,
    output logic             v_o,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic             s_o,
    output logic [1:0]       m_o
`ifdef DAG_PARITY_EN
    ,
    output logic             p_o
`endif
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             s_q, s_d;
    logic [1:0]       m_q, m_d;
    logic [WIDTH-1:0] op_res;

    always_comb begin
        op_res = '0;
        case (dag_op_e'(m_i))
            OP_AND:  op_res = x_i & y_i;
            OP_OR:   op_res = x_i | y_i;
            OP_XOR:  op_res = x_i ^ y_i;
            OP_XNOR: op_res = ~(x_i ^ y_i);
            default: op_res = '0;
        endcase
    end

    // Valid follows upstream every cycle so bubbles pass; data only moves with a valid token.
    always_comb begin
        v_d = v_i;
        x_d = x_q;
        y_d = y_q;
        s_d = s_q;
        m_d = m_q;
        if (v_i) begin
            x_d = op_res;
            y_d = x_i ^ y_i;
            s_d = s_i ^ (^x_i);
            m_d = m_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
            s_q <= 1'b0;
            m_q <= 2'b00;
        end else begin
            v_q <= v_d;
            x_q <= x_d;
            y_q <= y_d;
            s_q <= s_d;
            m_q <= m_d;
        end
    end

    assign v_o = v_q;
    assign x_o = x_q;
    assign y_o = y_q;
    assign s_o = s_q;
    assign m_o = m_q;

`ifdef DAG_PARITY_EN
    logic p_q, p_d;

    // x_d/s_d already hold through bubbles, so the parity holds with them.
    assign p_d = (^x_d) ^ s_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_q <= 1'b0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;
`endif

endmodule

// File: rtl/bm_dag_log_pipe.sv
// DEPTH-stage registered DAG logic pipeline with per-transaction op mode and a saturating result counter.
// Define DAG_PARITY_EN to add the out_parity output.
module bm_dag_log_pipe
    import bm_dag_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             d_in,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out0,
    output logic             out1,
    output logic [CNT_W-1:0] out_count
`ifdef DAG_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Index 0 is the combinational seed; index k is the output of stage k.
    logic             v_s [0:DEPTH];
    logic [WIDTH-1:0] x_s [0:DEPTH];
    logic [WIDTH-1:0] y_s [0:DEPTH];
    logic             s_s [0:DEPTH];
    logic [1:0]       m_s [0:DEPTH];
`ifdef DAG_PARITY_EN
    logic             p_s [1:DEPTH];
`endif

    assign v_s[0] = in_valid;
    assign x_s[0] = a_in;
    assign y_s[0] = b_in;
    assign s_s[0] = c_in & d_in;
    assign m_s[0] = mode;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        bm_dag_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clock (clock),
            .reset (reset),
            .v_i   (v_s[k-1]),
            .x_i   (x_s[k-1]),
            .y_i   (y_s[k-1]),
            .s_i   (s_s[k-1]),
            .m_i   (m_s[k-1]),
            .v_o   (v_s[k]),
            .x_o   (x_s[k]),
            .y_o   (y_s[k]),
            .s_o   (s_s[k]),
            .m_o   (m_s[k])
`ifdef DAG_PARITY_EN
            ,
            .p_o   (p_s[k])
`endif
        );
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts on the same edge the final stage loads, so out_count already includes the
    // result shown on out_valid; clear wins over a simultaneous delivery.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (v_s[DEPTH-1] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = v_s[DEPTH];
    assign out0      = x_s[DEPTH];
    assign out1      = s_s[DEPTH];
    assign out_count = cnt_q;
`ifdef DAG_PARITY_EN
    assign out_parity = p_s[DEPTH];
`endif

endmodule
